// File: rtl/gray_pkg.sv
// gray_pkg
// Shared constants and types for the RGB-to-grayscale pipeline.
// Mode encodings, the luma coefficient sets (8 fractional bits, each set
// summing to 256), the rounding bias, and a helper that maps a mode to its
// coefficient triple.
package gray_pkg;

  localparam int FRAC_BITS  = 8;
  localparam int ROUND_BIAS = 128;
  // Nine bits are needed so the green-passthrough set can hold 256.
  localparam int COEF_W     = 9;

  typedef enum logic [1:0] {
    MODE_BT601 = 2'd0,
    MODE_BT709 = 2'd1,
    MODE_AVG   = 2'd2,
    MODE_GREEN = 2'd3
  } mode_e;

  typedef struct packed {
    logic [COEF_W-1:0] r;
    logic [COEF_W-1:0] g;
    logic [COEF_W-1:0] b;
  } coefSet_t;

  localparam coefSet_t COEF_BT601 = '{r: 9'd77, g: 9'd150, b: 9'd29};
  localparam coefSet_t COEF_BT709 = '{r: 9'd54, g: 9'd183, b: 9'd19};
  localparam coefSet_t COEF_AVG   = '{r: 9'd85, g: 9'd85,  b: 9'd86};
  localparam coefSet_t COEF_GREEN = '{r: 9'd0,  g: 9'd256, b: 9'd0};

  function automatic coefSet_t selectCoefs(input logic [1:0] mode);
    coefSet_t coefs;
    case (mode_e'(mode))
      MODE_BT601: coefs = COEF_BT601;
      MODE_BT709: coefs = COEF_BT709;
      MODE_AVG:   coefs = COEF_AVG;
      default:    coefs = COEF_GREEN;
    endcase
    return coefs;
  endfunction

endpackage

// File: rtl/gray_lane.sv
// gray_lane
// One pixel's worth of the conversion datapath: the stage-2 products and
// the stage-3 rounded, saturated gray value. Valid tracking and stalls are
// owned by the top level; this block only loads when told to advance.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   adv2_i          load the product registers from the stage-1 pixel
//   adv3_i          load the gray register from the product registers
//   r_i, g_i, b_i   stage-1 registered colour components
//   coef_i          stage-1 registered coefficient set
//   gray_o          stage-3 gray value
module gray_lane
  import gray_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv2_i,
  input  logic             adv3_i,
  input  logic [PIX_W-1:0] r_i,
  input  logic [PIX_W-1:0] g_i,
  input  logic [PIX_W-1:0] b_i,
  input  coefSet_t         coef_i,
  output logic [PIX_W-1:0] gray_o
);

  localparam int PROD_W  = PIX_W + COEF_W;
  localparam int SUM_W   = PIX_W + 11;
  localparam int SHIFT_W = SUM_W - FRAC_BITS;

  logic [PROD_W-1:0]  prodR_d, prodG_d, prodB_d;
  logic [PROD_W-1:0]  prodR_q, prodG_q, prodB_q;
  logic [SUM_W-1:0]   sum_d;
  logic [SHIFT_W-1:0] scaled;
  logic [PIX_W-1:0]   gray_d, gray_q;

  // Operands are widened to the full product width before multiplying so
  // that no product bit is lost.
  always_comb begin
    prodR_d = PROD_W'(r_i) * PROD_W'(coef_i.r);
    prodG_d = PROD_W'(g_i) * PROD_W'(coef_i.g);
    prodB_d = PROD_W'(b_i) * PROD_W'(coef_i.b);
  end

  // Round half up by adding the bias before dropping the fractional bits,
  // then clamp anything that overflows the output width to full scale.
  always_comb begin
    sum_d  = SUM_W'(prodR_q) + SUM_W'(prodG_q) + SUM_W'(prodB_q) + SUM_W'(ROUND_BIAS);
    scaled = SHIFT_W'(sum_d >> FRAC_BITS);
    gray_d = scaled[PIX_W-1:0];
    if (|scaled[SHIFT_W-1:PIX_W]) begin
      gray_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prodR_q <= '0;
      prodG_q <= '0;
      prodB_q <= '0;
      gray_q  <= '0;
    end else begin
      if (adv2_i) begin
        prodR_q <= prodR_d;
        prodG_q <= prodG_d;
        prodB_q <= prodB_d;
      end
      if (adv3_i) begin
        gray_q <= gray_d;
      end
    end
  end

  assign gray_o = gray_q;

endmodule

// File: rtl/rgb_to_gray_pipe.sv
// rgb_to_gray_pipe
// Three-stage RGB-to-grayscale converter with valid/ready flow control.
// Stage 1 captures the pixels, sideband and the coefficient set chosen by
// mode; stages 2 and 3 live in one gray_lane per pixel. Each stage advances
// independently so bubbles collapse while the output is stalled.
// Ports:
//   clk, rst_n                   clock and asynchronous active-low reset
//   mode                         coefficient set for the accepted beat
//   in_valid, in_ready           input handshake
//   in_r, in_g, in_b             packed components, lane k at [k*PIX_W +: PIX_W]
//   in_sof, in_eol               input sideband
//   out_valid, out_ready         output handshake
//   out_gray                     packed gray, same lane order as the input
//   out_sof, out_eol             sideband delayed with the data
module rgb_to_gray_pipe
  import gray_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*PIX_W-1:0] in_r,
  input  logic [LANES*PIX_W-1:0] in_g,
  input  logic [LANES*PIX_W-1:0] in_b,
  input  logic                   in_sof,
  input  logic                   in_eol,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*PIX_W-1:0] out_gray,
  output logic                   out_sof,
  output logic                   out_eol
);

  logic                   valid1_q, valid2_q, valid3_q;
  logic                   adv1, adv2, adv3;
  logic [LANES*PIX_W-1:0] r1_q, g1_q, b1_q;
  coefSet_t               coef1_d, coef1_q;
  logic                   sof1_q, eol1_q, sof2_q, eol2_q, sof3_q, eol3_q;

  // A stage may move forward when it is empty or when the stage after it
  // is moving, so in_ready follows out_ready combinationally.
  always_comb begin
    adv3    = !valid3_q || out_ready;
    adv2    = !valid2_q || adv3;
    adv1    = !valid1_q || adv2;
    coef1_d = selectCoefs(mode);
  end

  assign in_ready = adv1;

  // Stage registers for valid bits, stage-1 pixels and coefficients, and the
  // sideband that travels alongside. The pixel registers load even for a
  // bubble; their contents are ignored while the matching valid bit is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      valid3_q <= 1'b0;
      r1_q     <= '0;
      g1_q     <= '0;
      b1_q     <= '0;
      coef1_q  <= '0;
      sof1_q   <= 1'b0;
      eol1_q   <= 1'b0;
      sof2_q   <= 1'b0;
      eol2_q   <= 1'b0;
      sof3_q   <= 1'b0;
      eol3_q   <= 1'b0;
    end else begin
      if (adv1) begin
        valid1_q <= in_valid;
        r1_q     <= in_r;
        g1_q     <= in_g;
        b1_q     <= in_b;
        coef1_q  <= coef1_d;
        sof1_q   <= in_sof;
        eol1_q   <= in_eol;
      end
      if (adv2) begin
        valid2_q <= valid1_q;
        sof2_q   <= sof1_q;
        eol2_q   <= eol1_q;
      end
      if (adv3) begin
        valid3_q <= valid2_q;
        sof3_q   <= sof2_q;
        eol3_q   <= eol2_q;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : gLane
    gray_lane #(.PIX_W(PIX_W)) uLane (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv2_i (adv2),
      .adv3_i (adv3),
      .r_i    (r1_q[k*PIX_W +: PIX_W]),
      .g_i    (g1_q[k*PIX_W +: PIX_W]),
      .b_i    (b1_q[k*PIX_W +: PIX_W]),
      .coef_i (coef1_q),
      .gray_o (out_gray[k*PIX_W +: PIX_W])
    );
  end

  assign out_valid = valid3_q;
  assign out_sof   = sof3_q;
  assign out_eol   = eol3_q;

endmodule

// File: tb/tb_rgb_to_gray_pipe.sv
// tb_rgb_to_gray_pipe
// Self-checking bench for rgb_to_gray_pipe. Instance A is 8-bit, 2 lanes and
// carries the stream, stall and reset scenarios; instance B is 10-bit,
// 2 lanes and covers the wider component width.
module tb_rgb_to_gray_pipe;

  localparam int AW = 8;
  localparam int AL = 2;
  localparam int BW = 10;
  localparam int BL = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic [1:0]       aMode;
  logic             aInValid, aInReady, aInSof, aInEol;
  logic [AL*AW-1:0] aInR, aInG, aInB, aOutGray;
  logic             aOutValid, aOutReady, aOutSof, aOutEol;

  logic [1:0]       bMode;
  logic             bInValid, bInReady, bInSof, bInEol;
  logic [BL*BW-1:0] bInR, bInG, bInB, bOutGray;
  logic             bOutValid, bOutReady, bOutSof, bOutEol;

  rgb_to_gray_pipe #(.PIX_W(AW), .LANES(AL)) dutA (
    .clk(clk), .rst_n(rst_n), .mode(aMode),
    .in_valid(aInValid), .in_ready(aInReady),
    .in_r(aInR), .in_g(aInG), .in_b(aInB),
    .in_sof(aInSof), .in_eol(aInEol),
    .out_valid(aOutValid), .out_ready(aOutReady),
    .out_gray(aOutGray), .out_sof(aOutSof), .out_eol(aOutEol)
  );

  rgb_to_gray_pipe #(.PIX_W(BW), .LANES(BL)) dutB (
    .clk(clk), .rst_n(rst_n), .mode(bMode),
    .in_valid(bInValid), .in_ready(bInReady),
    .in_r(bInR), .in_g(bInG), .in_b(bInB),
    .in_sof(bInSof), .in_eol(bInEol),
    .out_valid(bOutValid), .out_ready(bOutReady),
    .out_gray(bOutGray), .out_sof(bOutSof), .out_eol(bOutEol)
  );

  typedef struct {
    logic [AL*AW-1:0] r;
    logic [AL*AW-1:0] g;
    logic [AL*AW-1:0] b;
    logic [1:0]       mode;
    logic             sof;
    logic             eol;
    bit               useExp;
    logic [AW-1:0]    expG;
  } stim_t;

  typedef struct {
    logic [AL*AW-1:0] gray;
    logic             sof;
    logic             eol;
    int               cyc;
  } exp_t;

  stim_t stimQ[$];
  exp_t  expQ[$];
  int    nChecks = 0;
  int    nErrors = 0;

  // Reference: weighted sum with the published coefficients, rounded half
  // up, clamped to the output range.
  function automatic int refGray(input int r, input int g, input int b,
                                 input int mode, input int w);
    int cr[4] = '{77, 54, 85, 0};
    int cg[4] = '{150, 183, 85, 256};
    int cb[4] = '{29, 19, 86, 0};
    int s;
    int maxV;
    maxV = (1 << w) - 1;
    s = (r * cr[mode] + g * cg[mode] + b * cb[mode] + 128) / 256;
    if (s > maxV) s = maxV;
    return s;
  endfunction

  // Drives stimQ into instance A and checks every output against expQ,
  // along with hold-while-stalled, in_ready and optional latency.
  task automatic runStream(input bit randReady, input bit randGaps,
                           input bit checkLat, input string tag);
    int         cyc = 0;
    int         inflight = 0;
    bit         stallPrev = 0;
    bit         expIn;
    logic [AL*AW-1:0] prevGray = '0;
    logic       prevSof = 0, prevEol = 0;
    stim_t      s;
    exp_t       e;
    while ((stimQ.size() != 0 || expQ.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      if (stallPrev) begin
        nChecks++;
        if (aOutValid !== 1'b1 || aOutGray !== prevGray ||
            aOutSof !== prevSof || aOutEol !== prevEol) begin
          nErrors++;
          $display("[TB] FAIL %s hold: valid=%b gray=%h sof=%b eol=%b, required valid=1 gray=%h sof=%b eol=%b",
                   tag, aOutValid, aOutGray, aOutSof, aOutEol, prevGray, prevSof, prevEol);
        end
      end
      aOutReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stimQ.size() != 0 && (!randGaps || $urandom_range(0, 3) != 0)) begin
        s = stimQ[0];
        aInValid = 1'b1;
        aInR = s.r; aInG = s.g; aInB = s.b;
        aMode = s.mode; aInSof = s.sof; aInEol = s.eol;
      end else begin
        aInValid = 1'b0;
        aInR = 16'($urandom()); aInG = 16'($urandom()); aInB = 16'($urandom());
        aMode = 2'($urandom()); aInSof = 1'($urandom()); aInEol = 1'($urandom());
      end
      #1;
      expIn = !(inflight == 3 && !aOutReady);
      nChecks++;
      if (aInReady !== expIn) begin
        nErrors++;
        $display("[TB] FAIL %s in_ready: got %b, required %b (in flight %0d)",
                 tag, aInReady, expIn, inflight);
      end
      if (aOutValid === 1'b1) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nErrors++;
          $display("[TB] FAIL %s spurious: out_valid=1 gray=%h, required no beat", tag, aOutGray);
        end else if (aOutReady) begin
          e = expQ.pop_front();
          inflight--;
          nChecks++;
          if (aOutGray !== e.gray || aOutSof !== e.sof || aOutEol !== e.eol) begin
            nErrors++;
            $display("[TB] FAIL %s data: gray=%h sof=%b eol=%b, required gray=%h sof=%b eol=%b",
                     tag, aOutGray, aOutSof, aOutEol, e.gray, e.sof, e.eol);
          end
          if (checkLat) begin
            nChecks++;
            if (cyc - e.cyc != 3) begin
              nErrors++;
              $display("[TB] FAIL %s latency: got %0d, required 3", tag, cyc - e.cyc);
            end
          end
        end
      end
      if (aInValid && aInReady) begin
        s = stimQ.pop_front();
        for (int k = 0; k < AL; k++) begin
          e.gray[k*AW +: AW] = s.useExp ? s.expG :
            8'(refGray(int'(s.r[k*AW +: AW]), int'(s.g[k*AW +: AW]),
                       int'(s.b[k*AW +: AW]), int'(s.mode), AW));
        end
        e.sof = s.sof;
        e.eol = s.eol;
        e.cyc = cyc;
        expQ.push_back(e);
        inflight++;
      end
      stallPrev = aOutValid && !aOutReady;
      prevGray  = aOutGray;
      prevSof   = aOutSof;
      prevEol   = aOutEol;
      cyc++;
    end
    aInValid = 1'b0;
    nChecks++;
    if (stimQ.size() != 0 || expQ.size() != 0) begin
      nErrors++;
      $display("[TB] FAIL %s timeout: %0d inputs and %0d outputs pending, required 0",
               tag, stimQ.size(), expQ.size());
      stimQ.delete();
      expQ.delete();
    end
  endtask

  task automatic pushDirected(input logic [AW-1:0] r, input logic [AW-1:0] g,
                              input logic [AW-1:0] b, input logic [1:0] mode,
                              input logic [AW-1:0] expG);
    stim_t s;
    s.r = {r, r}; s.g = {g, g}; s.b = {b, b};
    s.mode = mode; s.sof = 1'b0; s.eol = 1'b1;
    s.useExp = 1'b1; s.expG = expG;
    stimQ.push_back(s);
  endtask

  task automatic pushRandom(input int n);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s.r = 16'($urandom()); s.g = 16'($urandom()); s.b = 16'($urandom());
      s.mode = 2'($urandom());
      s.sof = (i == 0);
      s.eol = 1'($urandom());
      s.useExp = 1'b0;
      s.expG = '0;
      stimQ.push_back(s);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    aInValid = 0; aOutReady = 1; aMode = 0; aInSof = 0; aInEol = 0;
    aInR = '0; aInG = '0; aInB = '0;
    bInValid = 0; bOutReady = 1; bMode = 0; bInSof = 0; bInEol = 0;
    bInR = '0; bInG = '0; bInB = '0;
    #12;
    nChecks++;
    if (aOutValid !== 1'b0 || aOutGray !== '0 || aOutSof !== 1'b0 || aOutEol !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL reset A: valid=%b gray=%h sof=%b eol=%b, required all 0",
               aOutValid, aOutGray, aOutSof, aOutEol);
    end
    nChecks++;
    if (bOutValid !== 1'b0 || bOutGray !== '0) begin
      nErrors++;
      $display("[TB] FAIL reset B: valid=%b gray=%h, required all 0", bOutValid, bOutGray);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nChecks++;
    if (aInReady !== 1'b1) begin
      nErrors++;
      $display("[TB] FAIL reset ready: in_ready=%b, required 1", aInReady);
    end
  endtask

  task automatic test_coefficients;
    pushDirected(8'd255, 8'd0,   8'd0,   2'd0, 8'd77);
    pushDirected(8'd255, 8'd255, 8'd255, 2'd0, 8'd255);
    pushDirected(8'd0,   8'd255, 8'd0,   2'd1, 8'd182);
    pushDirected(8'd10,  8'd20,  8'd30,  2'd2, 8'd20);
    pushDirected(8'd9,   8'd200, 8'd40,  2'd3, 8'd200);
    runStream(1'b0, 1'b1, 1'b0, "coef");
  endtask

  task automatic test_mode_switch;
    pushDirected(8'd255, 8'd0, 8'd0, 2'd0, 8'd77);
    pushDirected(8'd255, 8'd0, 8'd0, 2'd1, 8'd54);
    runStream(1'b0, 1'b0, 1'b1, "modeswitch");
  endtask

  task automatic test_back_to_back;
    pushRandom(16);
    runStream(1'b0, 1'b0, 1'b1, "b2b");
  endtask

  task automatic test_stall;
    pushRandom(120);
    runStream(1'b1, 1'b1, 1'b0, "stall");
  endtask

  task automatic test_reset_midstream;
    @(negedge clk);
    aOutReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      aInValid = 1'b1;
      aInR = 16'($urandom()); aInG = 16'($urandom()); aInB = 16'($urandom());
      aMode = 2'($urandom()); aInSof = 1'b1; aInEol = 1'b1;
      @(negedge clk);
    end
    aInValid = 1'b0;
    #1;
    nChecks++;
    if (aOutValid !== 1'b1 || aInReady !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL midreset full: out_valid=%b in_ready=%b, required 1 0", aOutValid, aInReady);
    end
    #1;
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (aOutValid !== 1'b0 || aOutGray !== '0 || aOutSof !== 1'b0 || aOutEol !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL midreset async: valid=%b gray=%h sof=%b eol=%b, required all 0",
               aOutValid, aOutGray, aOutSof, aOutEol);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    aOutReady = 1'b1;
    @(negedge clk);
    nChecks++;
    if (aInReady !== 1'b1) begin
      nErrors++;
      $display("[TB] FAIL midreset ready: in_ready=%b, required 1", aInReady);
    end
    for (int i = 0; i < 6; i++) begin
      nChecks++;
      if (aOutValid !== 1'b0) begin
        nErrors++;
        $display("[TB] FAIL midreset stale: out_valid=%b at cycle %0d, required 0", aOutValid, i);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wide;
    int r0, g0, b0, r1, g1, b1, m, waitCyc;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        r0 = 1023; g0 = 1023; b0 = 1023; r1 = 1023; g1 = 1023; b1 = 1023; m = 0;
      end else begin
        r0 = $urandom_range(0, 1023); g0 = $urandom_range(0, 1023); b0 = $urandom_range(0, 1023);
        r1 = $urandom_range(0, 1023); g1 = $urandom_range(0, 1023); b1 = $urandom_range(0, 1023);
        m = $urandom_range(0, 3);
      end
      @(negedge clk);
      bOutReady = 1'b1;
      bInValid = 1'b1;
      bMode = 2'(m);
      bInR = {10'(r1), 10'(r0)}; bInG = {10'(g1), 10'(g0)}; bInB = {10'(b1), 10'(b0)};
      bInSof = 1'(i & 1); bInEol = 1'b0;
      @(negedge clk);
      bInValid = 1'b0;
      waitCyc = 0;
      while (bOutValid !== 1'b1 && waitCyc < 10) begin
        @(negedge clk);
        waitCyc++;
      end
      nChecks++;
      if (bOutValid !== 1'b1) begin
        nErrors++;
        $display("[TB] FAIL wide timeout: no output for beat %0d, required one", i);
      end else if (bOutGray[9:0] !== 10'(refGray(r0, g0, b0, m, BW)) ||
                   bOutGray[19:10] !== 10'(refGray(r1, g1, b1, m, BW)) ||
                   bOutSof !== 1'(i & 1)) begin
        nErrors++;
        $display("[TB] FAIL wide data: lanes %0d %0d sof %b, required %0d %0d sof %b",
                 bOutGray[9:0], bOutGray[19:10], bOutSof,
                 refGray(r0, g0, b0, m, BW), refGray(r1, g1, b1, m, BW), 1'(i & 1));
      end
      if (i == 0) begin
        nChecks++;
        if (bOutGray !== {10'd1023, 10'd1023}) begin
          nErrors++;
          $display("[TB] FAIL wide fullscale: gray=%h, required %h", bOutGray, {10'd1023, 10'd1023});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_coefficients();
    test_mode_switch();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule
